// File: rtl/cmul_rr_scheduler_if.sv
// Handshake and datapath bundle between requesters, the scheduler and the shared complex multiplier.
// master = requester/multiplier side, slave = scheduler.
interface cmul_rr_scheduler_if #(
  parameter int N_REQ   = 4,
  parameter int A_WIDTH = 10,
  parameter int B_WIDTH = 15
);
  localparam int C_WIDTH = A_WIDTH + B_WIDTH + 1;
  localparam int ID_W    = $clog2(N_REQ);

  logic [N_REQ-1:0]         req_valid;
  logic [N_REQ-1:0]         req_ready;
  logic [N_REQ*A_WIDTH-1:0] req_a_re;
  logic [N_REQ*A_WIDTH-1:0] req_a_im;
  logic [N_REQ*B_WIDTH-1:0] req_b_re;
  logic [N_REQ*B_WIDTH-1:0] req_b_im;
  logic [A_WIDTH-1:0]       mult_a_re;
  logic [A_WIDTH-1:0]       mult_a_im;
  logic [B_WIDTH-1:0]       mult_b_re;
  logic [B_WIDTH-1:0]       mult_b_im;
  logic [C_WIDTH-1:0]       mult_c_re;
  logic [C_WIDTH-1:0]       mult_c_im;
  logic                     res_valid;
  logic [ID_W-1:0]          res_id;
  logic [C_WIDTH-1:0]       res_re;
  logic [C_WIDTH-1:0]       res_im;
  logic                     drain;
  logic                     idle;

  modport master (
    output req_valid, req_a_re, req_a_im, req_b_re, req_b_im, mult_c_re, mult_c_im, drain,
    input  req_ready, mult_a_re, mult_a_im, mult_b_re, mult_b_im, res_valid, res_id, res_re, res_im, idle
  );

  modport slave (
    input  req_valid, req_a_re, req_a_im, req_b_re, req_b_im, mult_c_re, mult_c_im, drain,
    output req_ready, mult_a_re, mult_a_im, mult_b_re, mult_b_im, res_valid, res_id, res_re, res_im, idle
  );
endinterface

// File: rtl/cmul_rr_scheduler.sv
// Round-robin share of one pipelined complex multiplier; product returns 1+MULT_DELAY cycles after handshake.
// No result backpressure; req_ready is one-hot from req_valid. Grant counters exist only with CMUL_SCHED_STATS_EN.
module cmul_rr_scheduler #(
  parameter int N_REQ      = 4,
  parameter int A_WIDTH    = 10,
  parameter int B_WIDTH    = 15,
  parameter int MULT_DELAY = 3
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
`ifdef CMUL_SCHED_STATS_EN
  input  logic                i_stat_clr,
  output logic [N_REQ*32-1:0] o_stat_grants,
`endif
  cmul_rr_scheduler_if.slave  bus
);
  localparam int C_WIDTH = A_WIDTH + B_WIDTH + 1;
  localparam int ID_W    = $clog2(N_REQ);

  typedef enum logic [1:0] {S_RUN, S_DRAIN, S_IDLE} state_t;

  state_t              r_state;
  logic [ID_W-1:0]     r_ptr;
  logic [A_WIDTH-1:0]  r_a_re, r_a_im;
  logic [B_WIDTH-1:0]  r_b_re, r_b_im;
  logic [MULT_DELAY:0] r_tag_vld;
  logic [ID_W-1:0]     r_tag_id [MULT_DELAY+1];

  logic                w_grant_en;
  logic                w_found;
  logic                w_hs;
  logic [ID_W:0]       w_idx;
  logic [ID_W-1:0]     w_sel;
  logic [ID_W-1:0]     w_ptr_nxt;
  logic [C_WIDTH-1:0]  w_res_re, w_res_im;

  // Reset gates the grant so nothing is accepted while the pipeline is being flushed.
  assign w_grant_en = i_rst_n && (r_state == S_RUN) && !bus.drain;

  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    w_idx   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      w_idx = {1'b0, r_ptr} + (ID_W+1)'(k);
      if (w_idx >= (ID_W+1)'(N_REQ)) w_idx = w_idx - (ID_W+1)'(N_REQ);
      if (!w_found && bus.req_valid[w_idx[ID_W-1:0]]) begin
        w_found = 1'b1;
        w_sel   = w_idx[ID_W-1:0];
      end
    end
  end

  assign w_hs          = w_grant_en && w_found;
  assign w_ptr_nxt     = (w_sel == ID_W'(N_REQ-1)) ? '0 : w_sel + 1'b1;
  assign bus.req_ready = w_hs ? (N_REQ'(1) << w_sel) : '0;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ptr  <= '0;
      r_a_re <= '0;
      r_a_im <= '0;
      r_b_re <= '0;
      r_b_im <= '0;
    end else if (w_hs) begin
      r_ptr  <= w_ptr_nxt;
      r_a_re <= bus.req_a_re[w_sel*A_WIDTH +: A_WIDTH];
      r_a_im <= bus.req_a_im[w_sel*A_WIDTH +: A_WIDTH];
      r_b_re <= bus.req_b_re[w_sel*B_WIDTH +: B_WIDTH];
      r_b_im <= bus.req_b_im[w_sel*B_WIDTH +: B_WIDTH];
    end
  end

  // Tags shift every cycle so they line up with the multiplier's fixed latency.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_tag_vld <= '0;
      for (int i = 0; i <= MULT_DELAY; i++) r_tag_id[i] <= '0;
    end else begin
      r_tag_vld   <= {r_tag_vld[MULT_DELAY-1:0], w_hs};
      r_tag_id[0] <= w_sel;
      for (int i = 1; i <= MULT_DELAY; i++) r_tag_id[i] <= r_tag_id[i-1];
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_RUN;
    end else begin
      case (r_state)
        S_RUN:   if (bus.drain) r_state <= S_DRAIN;
        S_DRAIN: begin
          if (!bus.drain)            r_state <= S_RUN;
          else if (r_tag_vld == '0) r_state <= S_IDLE;
        end
        S_IDLE:  if (!bus.drain) r_state <= S_RUN;
        default: r_state <= S_RUN;
      endcase
    end
  end

  assign w_res_re      = bus.mult_c_re;
  assign w_res_im      = bus.mult_c_im;
  assign bus.mult_a_re = r_a_re;
  assign bus.mult_a_im = r_a_im;
  assign bus.mult_b_re = r_b_re;
  assign bus.mult_b_im = r_b_im;
  assign bus.res_valid = r_tag_vld[MULT_DELAY];
  assign bus.res_id    = r_tag_id[MULT_DELAY];
  assign bus.res_re    = w_res_re;
  assign bus.res_im    = w_res_im;
  assign bus.idle      = ((r_state != S_RUN) || (bus.req_valid == '0)) && (r_tag_vld == '0);

`ifdef CMUL_SCHED_STATS_EN
  logic [31:0] r_grant_cnt [N_REQ];

  // Clear wins over a coincident grant.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < N_REQ; i++) r_grant_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (i_stat_clr)
          r_grant_cnt[i] <= '0;
        else if (w_hs && (w_sel == ID_W'(i)) && (r_grant_cnt[i] != '1))
          r_grant_cnt[i] <= r_grant_cnt[i] + 32'd1;
      end
    end
  end

  for (genvar g = 0; g < N_REQ; g++) begin : g_stat
    assign o_stat_grants[g*32 +: 32] = r_grant_cnt[g];
  end
`endif
endmodule
